// File: rtl/stage2_pool_sched_pkg.sv
// Shared definitions for the stage-2 pooling sequencer.
// The default geometry mirrors ST2_Pool_IW / ST2_Pool_IH / ST2_Pool_K from
// defines_cnn_core.v so the sequencer and the pooling core agree on frame size.
package stage2_pool_sched_pkg;

  localparam int ST2_POOL_IW = 24;
  localparam int ST2_POOL_IH = 24;
  localparam int ST2_POOL_K  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_t;

  // Number of complete pooling windows along one axis; trailing points are dropped.
  function automatic int pool_cells(input int len, input int k);
    return len / k;
  endfunction

endpackage

// File: rtl/stage2_pool_pos_cnt.sv
// Raster position counter for the stage-2 pooling input stream.
// x advances on every enabled point and wraps at IN_W-1, carrying into y;
// o_last flags the final point of the frame (both coordinates at their maximum).
module stage2_pool_pos_cnt #(
  parameter int IN_W = 24,
  parameter int IN_H = 24,
  parameter int XW   = $clog2(IN_W),
  parameter int YW   = $clog2(IN_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          clr,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (o_x == XW'(IN_W - 1));
  assign y_wrap = (o_y == YW'(IN_H - 1));
  assign o_last = x_wrap & y_wrap;

  // Advance the raster position; clear has priority so a new frame starts at (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_x <= '0;
      o_y <= '0;
    end else if (clr) begin
      o_x <= '0;
      o_y <= '0;
    end else if (en) begin
      if (x_wrap) begin
        o_x <= '0;
        o_y <= y_wrap ? '0 : o_y + 1'b1;
      end else begin
        o_x <= o_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage2_pool_sched.sv
// Frame sequencer between the stage-2 conv output stream and stage2_pooling_core.
// Gates the core's input valid to complete pooling windows, tags window phase,
// counts returned pooled results and reports frame completion / protocol errors.
// Optional drain watchdog: define ST2_POOL_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_start; any stream activity is an error
//   ST_RUN   | accepting fmap points, forwarding those inside full windows
//   ST_DRAIN | all points seen, waiting for the remaining pooled results
//   ST_DONE  | one-cycle frame-done pulse, then back to idle
module stage2_pool_sched
  import stage2_pool_sched_pkg::*;
#(
  parameter int IN_W    = ST2_POOL_IW,
  parameter int IN_H    = ST2_POOL_IH,
  parameter int POOL_K  = ST2_POOL_K,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_start,
  input  logic                        i_in_valid,
  output logic                        o_pool_valid,
  output logic [$clog2(POOL_K)-1:0]   o_win_col,
  output logic [$clog2(POOL_K)-1:0]   o_win_row,
  output logic                        o_win_last,
  input  logic                        i_pool_ot_valid,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic                        o_err,
  output logic [$clog2(pool_cells(IN_W, POOL_K) * pool_cells(IN_H, POOL_K) + 1)-1:0] o_out_cnt
);

  localparam int VW    = pool_cells(IN_W, POOL_K) * POOL_K;
  localparam int VH    = pool_cells(IN_H, POOL_K) * POOL_K;
  localparam int N_OUT = pool_cells(IN_W, POOL_K) * pool_cells(IN_H, POOL_K);
  localparam int XW    = $clog2(IN_W);
  localparam int YW    = $clog2(IN_H);
  localparam int PW    = $clog2(POOL_K);
  localparam int CW    = $clog2(N_OUT + 1);

  // One extra bit so VW == 2**XW does not wrap to zero in the compare.
  localparam logic [XW:0] VW_X = (XW + 1)'(VW);
  localparam logic [YW:0] VH_Y = (YW + 1)'(VH);
  localparam logic [XW:0] K_X  = (XW + 1)'(POOL_K);
  localparam logic [YW:0] K_Y  = (YW + 1)'(POOL_K);

  if (POOL_K < 2 || IN_W < POOL_K || IN_H < POOL_K || TIMEOUT < 2) begin : g_param_chk
    $error("stage2_pool_sched: need POOL_K >= 2, IN_W/IN_H >= POOL_K, TIMEOUT >= 2");
  end

  pool_state_t   state;
  logic [CW-1:0] out_cnt;
  logic          err;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          pos_last;
  logic          pos_en;
  logic          start_go;
  logic          acc_last;
  logic          cnt_full;

`ifdef ST2_POOL_TIMEOUT_EN
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wd_cnt;
`endif

  assign start_go = (state == ST_IDLE) & i_start;
  assign pos_en   = (state == ST_RUN) & i_in_valid;
  assign acc_last = pos_en & pos_last;
  assign cnt_full = (out_cnt == CW'(N_OUT));

  stage2_pool_pos_cnt #(
    .IN_W (IN_W),
    .IN_H (IN_H),
    .XW   (XW),
    .YW   (YW)
  ) u_pos_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pos_en),
    .clr     (start_go),
    .o_x     (x),
    .o_y     (y),
    .o_last  (pos_last)
  );

  // Zero-latency gating: fmap data reaches the core unregistered, so valid must too.
  assign o_pool_valid = pos_en & ({1'b0, x} < VW_X) & ({1'b0, y} < VH_Y);
  assign o_win_col    = PW'({1'b0, x} % K_X);
  assign o_win_row    = PW'({1'b0, y} % K_Y);
  assign o_win_last   = (o_win_col == PW'(POOL_K - 1)) & (o_win_row == PW'(POOL_K - 1));

  assign o_busy       = (state == ST_RUN) | (state == ST_DRAIN);
  assign o_frame_done = (state == ST_DONE);
  assign o_err        = err;
  assign o_out_cnt    = out_cnt;

  // Frame sequencing, result counting and sticky error capture.
  // Result counting is kept independent of the state move so a result that
  // coincides with the last input point is still counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      out_cnt <= '0;
      err     <= 1'b0;
`ifdef ST2_POOL_TIMEOUT_EN
      wd_cnt  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state   <= ST_RUN;
            out_cnt <= '0;
            err     <= 1'b0;
          end else if (i_in_valid || i_pool_ot_valid) begin
            err <= 1'b1;
          end
        end

        ST_RUN: begin
          if (i_pool_ot_valid) begin
            if (cnt_full) err <= 1'b1;
            else          out_cnt <= out_cnt + 1'b1;
          end
          if (acc_last) begin
            state <= ST_DRAIN;
`ifdef ST2_POOL_TIMEOUT_EN
            wd_cnt <= WD_LOAD;
`endif
          end
        end

        ST_DRAIN: begin
          if (i_in_valid) err <= 1'b1;
          if (i_pool_ot_valid) begin
            if (cnt_full) err <= 1'b1;
            else          out_cnt <= out_cnt + 1'b1;
          end
          if (cnt_full) begin
            state <= ST_DONE;
          end
`ifdef ST2_POOL_TIMEOUT_EN
          // Down-counter reloaded on every result; terminal count aborts the frame.
          else if (i_pool_ot_valid) begin
            wd_cnt <= WD_LOAD;
          end else if (wd_cnt <= WDW'(1)) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
`endif
        end

        ST_DONE: begin
          state <= ST_IDLE;
          if (i_in_valid || (i_pool_ot_valid && cnt_full)) err <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage2_pool_sched.sv
// Self-checking bench for stage2_pool_sched on a 5x5, K=2 frame.
// A point-index model predicts every output each cycle; directed frames pin the
// model with literal window positions, counts and pulse timing.
module tb_stage2_pool_sched;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int K    = 2;
  localparam int TMO  = 10;
  localparam int VW   = (W / K) * K;
  localparam int VH   = (H / K) * K;
  localparam int NOUT = (W / K) * (H / K);
  localparam int NPTS = W * H;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start;
  logic       i_in_valid;
  logic       o_pool_valid;
  logic [0:0] o_win_col;
  logic [0:0] o_win_row;
  logic       o_win_last;
  logic       i_pool_ot_valid;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_err;
  logic [2:0] o_out_cnt;

  stage2_pool_sched #(
    .IN_W    (W),
    .IN_H    (H),
    .POOL_K  (K),
    .TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_start         (i_start),
    .i_in_valid      (i_in_valid),
    .o_pool_valid    (o_pool_valid),
    .o_win_col       (o_win_col),
    .o_win_row       (o_win_row),
    .o_win_last      (o_win_last),
    .i_pool_ot_valid (i_pool_ot_valid),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done),
    .o_err           (o_err),
    .o_out_cnt       (o_out_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 idle, 1 streaming, 2 draining, 3 done pulse
  int m_phase = 0;
  int m_pt    = 0;
  int m_cnt   = 0;
  int m_err   = 0;
  int m_ref   = 0;
  int cyc     = 0;

  // per-frame observations
  int pv_cnt = 0;
  int sup_cnt = 0;
  int done_cnt = 0;
  int wl_q[$];
  bit done_seen = 0;
  int done_cyc = 0;
  int last_res_cyc = 0;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic count_result();
    if (m_cnt == NOUT) m_err = 1;
    else               m_cnt++;
  endtask

  // Compare outputs against the model, record observations, then step the model.
  task automatic cycle_check();
    int  x;
    int  y;
    int  e_pv;
    int  e_busy;
    bit  full;
    cyc++;
    if (!reset_n) begin
      m_phase = 0; m_pt = 0; m_cnt = 0; m_err = 0; m_ref = 0;
    end
    x = m_pt % W;
    y = m_pt / W;
    e_pv   = (i_in_valid && m_phase == 1 && x < VW && y < VH) ? 1 : 0;
    e_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
    cmp("pool_valid", int'(o_pool_valid), e_pv);
    if (e_pv == 1) begin
      cmp("win_col", int'(o_win_col), x % K);
      cmp("win_row", int'(o_win_row), y % K);
      cmp("win_last", int'(o_win_last), (x % K == K - 1 && y % K == K - 1) ? 1 : 0);
    end
    cmp("busy", int'(o_busy), e_busy);
    cmp("frame_done", int'(o_frame_done), (m_phase == 3) ? 1 : 0);
    cmp("err", int'(o_err), m_err);
    cmp("out_cnt", int'(o_out_cnt), m_cnt);

    if (m_phase == 0 && i_start && reset_n) begin
      pv_cnt = 0; sup_cnt = 0; done_cnt = 0; wl_q.delete();
    end
    if (o_pool_valid) pv_cnt++;
    if (m_phase == 1 && i_in_valid && !o_pool_valid) sup_cnt++;
    if (o_pool_valid && o_win_last) wl_q.push_back(m_pt);
    if (o_frame_done) begin
      done_cnt++;
      if (!done_seen) done_cyc = cyc;
      done_seen = 1;
    end
    if (i_pool_ot_valid) last_res_cyc = cyc;

    if (reset_n) begin
      case (m_phase)
        0: begin
          if (i_start) begin
            m_phase = 1; m_pt = 0; m_cnt = 0; m_err = 0;
          end else if (i_in_valid || i_pool_ot_valid) begin
            m_err = 1;
          end
        end
        1: begin
          if (i_pool_ot_valid) count_result();
          if (i_in_valid) begin
            m_pt++;
            if (m_pt == NPTS) begin
              m_phase = 2;
              m_ref = cyc;
            end
          end
        end
        2: begin
          full = (m_cnt == NOUT);
          if (i_in_valid) m_err = 1;
          if (i_pool_ot_valid) count_result();
          if (full) m_phase = 3;
          else if (i_pool_ot_valid) m_ref = cyc;
`ifdef ST2_POOL_TIMEOUT_EN
          else if (cyc - m_ref >= TMO - 1) begin
            m_phase = 3;
            m_err = 1;
          end
`endif
        end
        default: begin
          m_phase = 0;
          if (i_in_valid || (i_pool_ot_valid && m_cnt == NOUT)) m_err = 1;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    cmp("frame_done_seen", int'(done_seen), 1);
    if (done_seen) tick();
  endtask

  // One frame: rnd=0 streams points back to back and returns results in DRAIN.
  task automatic frame(input bit rnd, input int n_res);
    int pts;
    int res;
    int k;
    pts = 0; res = 0; k = 0;
    done_seen = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while ((pts < NPTS || res < n_res) && !done_seen && k < 400) begin
      i_in_valid = (pts < NPTS) && (!rnd || $urandom_range(3) != 0);
      if (rnd) i_pool_ot_valid = (res < n_res) && pts >= 8 && ($urandom_range(2) == 0);
      else     i_pool_ot_valid = (res < n_res) && pts >= NPTS && (k % 2 == 0);
      if (i_in_valid) pts++;
      if (i_pool_ot_valid) res++;
      tick();
      k++;
    end
    i_in_valid = 1'b0;
    i_pool_ot_valid = 1'b0;
    wait_done(60);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int wl_exp[4];
    wl_exp = '{6, 8, 16, 18};
    reset_n = 1'b0;
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_pool_ot_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // reset state
    cmp("rst_busy", int'(o_busy), 0);
    cmp("rst_done", int'(o_frame_done), 0);
    cmp("rst_err", int'(o_err), 0);
    cmp("rst_cnt", int'(o_out_cnt), 0);

    // clean frame, 25 back-to-back points, 4 results in drain
    done_seen = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_in_valid = 1'b1;
    repeat (NPTS) tick();
    i_in_valid = 1'b0;
    cmp("pv_count", pv_cnt, 16);
    cmp("suppressed", sup_cnt, 9);
    cmp("win_last_n", wl_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wl_q.size()) cmp("win_last_idx", wl_q[i], wl_exp[i]);
    end
    cmp("drain_busy", int'(o_busy), 1);
    tick();
    repeat (3) begin
      i_pool_ot_valid = 1'b1;
      tick();
      i_pool_ot_valid = 1'b0;
      tick();
    end
    i_pool_ot_valid = 1'b1;
    tick();
    i_pool_ot_valid = 1'b0;
    cmp("cnt_at_n", int'(o_out_cnt), 4);
    cmp("done_not_yet", int'(o_frame_done), 0);
    tick();
    cmp("done_pulse", int'(o_frame_done), 1);
    tick();
    cmp("done_one_cycle", int'(o_frame_done), 0);
    cmp("idle_busy", int'(o_busy), 0);
    cmp("clean_err", int'(o_err), 0);
    cmp("done_cnt", done_cnt, 1);

    // stream activity in idle
    i_in_valid = 1'b1;
    #1;
    cmp("idle_pool_valid", int'(o_pool_valid), 0);
    tick();
    i_in_valid = 1'b0;
    cmp("idle_err", int'(o_err), 1);
    done_seen = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cmp("start_clears_err", int'(o_err), 0);

    // fifth result arrives while count is already full
    i_in_valid = 1'b1;
    repeat (NPTS) tick();
    i_in_valid = 1'b0;
    repeat (3) begin
      i_pool_ot_valid = 1'b1;
      tick();
      i_pool_ot_valid = 1'b0;
      tick();
    end
    i_pool_ot_valid = 1'b1;
    tick();
    tick();
    i_pool_ot_valid = 1'b0;
    cmp("extra_cnt_sat", int'(o_out_cnt), 4);
    cmp("extra_err", int'(o_err), 1);
    cmp("extra_done", int'(o_frame_done), 1);
    tick();

    // reset in the middle of a frame
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_in_valid = 1'b1;
    repeat (7) tick();
    i_in_valid = 1'b0;
    cmp("mid_busy", int'(o_busy), 1);
    reset_n = 1'b0;
    #1;
    cmp("mid_rst_busy", int'(o_busy), 0);
    cmp("mid_rst_cnt", int'(o_out_cnt), 0);
    cmp("mid_rst_err", int'(o_err), 0);
    cmp("mid_rst_done", int'(o_frame_done), 0);
    tick();
    reset_n = 1'b1;
    tick();
    frame(1'b0, NOUT);
    cmp("after_rst_cnt", int'(o_out_cnt), 4);
    cmp("after_rst_err", int'(o_err), 0);

    // randomized frames, occasionally followed by a stray point in idle
    for (int f = 0; f < 8; f++) begin
      frame(1'b1, NOUT);
      if ($urandom_range(3) == 0) begin
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
      end
      tick();
    end

`ifdef ST2_POOL_TIMEOUT_EN
    // watchdog: only 3 of 4 results ever come back
    frame(1'b0, 3);
    cmp("wd_err", int'(o_err), 1);
    cmp("wd_cnt", int'(o_out_cnt), 3);
    cmp("wd_delay", done_cyc - last_res_cyc, TMO);
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
